// File: rtl/video_mode_sequencer.sv
// video_mode_sequencer
//   Steps a pattern generator through NUM_MODES modes, either automatically
//   every FRAMES_PER_MODE frames or from debounced next/prev buttons, and
//   crossfades over FADE_FRAMES frames on every mode change.
//   Everything runs in the pixel-clock domain.
//
// Ports
//   I_pxl_clk      pixel clock, rising edge
//   I_rst_n        asynchronous active-low reset
//   I_vs, I_vs_pol vertical sync and its polarity (1 = active high)
//   I_auto_en      enable automatic advance
//   I_btn_next     raw next button, active high, asynchronous
//   I_btn_prev     raw prev button, active high, asynchronous
//   O_mode         current mode
//   O_next_mode    fade target (equals O_mode while holding)
//   O_blend        weight of O_next_mode, 0 while holding
//   O_fading       high during a crossfade
//   O_mode_change  one-cycle pulse when O_mode updates
//   O_frame_tick   one-cycle pulse per detected frame
module video_mode_sequencer #(
  parameter int MODE_W          = 3,
  parameter int NUM_MODES       = 8,
  parameter int FRAMES_PER_MODE = 64,
  parameter int FADE_FRAMES     = 16,
  parameter int DEBOUNCE_CYCLES = 1_000_000,
  parameter int CNT_W           = 20
) (
  input  logic              I_pxl_clk,
  input  logic              I_rst_n,
  input  logic              I_vs,
  input  logic              I_vs_pol,
  input  logic              I_auto_en,
  input  logic              I_btn_next,
  input  logic              I_btn_prev,
  output logic [MODE_W-1:0] O_mode,
  output logic [MODE_W-1:0] O_next_mode,
  output logic [7:0]        O_blend,
  output logic              O_fading,
  output logic              O_mode_change,
  output logic              O_frame_tick
);

  localparam int FRAME_W = (FRAMES_PER_MODE > 1) ? $clog2(FRAMES_PER_MODE) : 1;
  localparam int STEP    = 256 / FADE_FRAMES;

  localparam logic [MODE_W-1:0]  LAST_MODE  = MODE_W'(NUM_MODES - 1);
  localparam logic [FRAME_W-1:0] FRAME_LAST = FRAME_W'(FRAMES_PER_MODE - 1);
  localparam logic [7:0]         FADE_LAST  = 8'(FADE_FRAMES - 1);
  localparam logic [CNT_W-1:0]   DEB_LAST   = CNT_W'(DEBOUNCE_CYCLES - 1);

  typedef enum logic {HOLD, FADE} state_t;

  // ---------------------------------------------------------------------------
  // Frame detection: a frame ends when the active sync level drops.
  // ---------------------------------------------------------------------------
  logic vs_act, vs_act_q, tick, frame_tick_q;

  assign vs_act = ~(I_vs ^ I_vs_pol);
  assign tick   = vs_act_q & ~vs_act;

  // NOTE: sequential state is written with non-blocking assignments so every
  // register samples the pre-edge value of every other register.
  always_ff @(posedge I_pxl_clk or negedge I_rst_n) begin
    if (!I_rst_n) begin
      vs_act_q     <= 1'b0;
      frame_tick_q <= 1'b0;
    end else begin
      vs_act_q     <= vs_act;
      frame_tick_q <= tick;
    end
  end

  // ---------------------------------------------------------------------------
  // Button conditioning: bit 0 = next, bit 1 = prev.
  // The debounced level only moves after DEBOUNCE_CYCLES consecutive
  // synchronised samples disagree with it; a press is its rising edge.
  // ---------------------------------------------------------------------------
  logic [1:0] btn_raw, press;

  assign btn_raw = {I_btn_prev, I_btn_next};

  for (genvar g = 0; g < 2; g++) begin : g_btn
    logic             sync1, sync2, level, press_q;
    logic [CNT_W-1:0] cnt;

    always_ff @(posedge I_pxl_clk or negedge I_rst_n) begin
      if (!I_rst_n) begin
        sync1   <= 1'b0;
        sync2   <= 1'b0;
        level   <= 1'b0;
        press_q <= 1'b0;
        cnt     <= '0;
      end else begin
        sync1   <= btn_raw[g];
        sync2   <= sync1;
        press_q <= 1'b0;
        if (sync2 == level) begin
          cnt <= '0;
        end else if (cnt == DEB_LAST) begin
          level   <= sync2;
          press_q <= sync2;
          cnt     <= '0;
        end else begin
          cnt <= cnt + CNT_W'(1);
        end
      end
    end

    assign press[g] = press_q;
  end

  // ---------------------------------------------------------------------------
  // Mode FSM
  // ---------------------------------------------------------------------------
  state_t             state, state_d;
  logic [FRAME_W-1:0] frame_cnt, frame_cnt_d;
  logic [7:0]         fade_cnt, fade_cnt_d;
  logic [MODE_W-1:0]  mode_q, mode_d, next_q, next_d;
  logic [MODE_W-1:0]  inc_mode, dec_mode, target;
  logic [7:0]         blend_q, blend_d;
  logic [15:0]        blend_full;
  logic               fading_q, fading_d, change_q, change_d, enter;

  assign inc_mode = (mode_q == LAST_MODE) ? '0 : mode_q + MODE_W'(1);
  assign dec_mode = (mode_q == '0) ? LAST_MODE : mode_q - MODE_W'(1);

  always_ff @(posedge I_pxl_clk or negedge I_rst_n) begin
    if (!I_rst_n) begin
      state     <= HOLD;
      frame_cnt <= '0;
      fade_cnt  <= '0;
      mode_q    <= '0;
      next_q    <= '0;
      blend_q   <= '0;
      fading_q  <= 1'b0;
      change_q  <= 1'b0;
    end else begin
      state     <= state_d;
      frame_cnt <= frame_cnt_d;
      fade_cnt  <= fade_cnt_d;
      mode_q    <= mode_d;
      next_q    <= next_d;
      blend_q   <= blend_d;
      fading_q  <= fading_d;
      change_q  <= change_d;
    end
  end

  // NOTE: every signal gets a default before the case so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d     = state;
    frame_cnt_d = frame_cnt;
    fade_cnt_d  = fade_cnt;
    mode_d      = mode_q;
    next_d      = next_q;
    blend_d     = blend_q;
    fading_d    = fading_q;
    change_d    = 1'b0;
    enter       = 1'b0;
    target      = mode_q;
    blend_full  = '0;

    case (state)
      HOLD: begin
        // Simultaneous next+prev cancel each other; a single press beats auto.
        if (press[0] ^ press[1]) begin
          enter  = 1'b1;
          target = press[0] ? inc_mode : dec_mode;
        end else if (tick && I_auto_en) begin
          if (frame_cnt == FRAME_LAST) begin
            enter  = 1'b1;
            target = inc_mode;
          end else begin
            frame_cnt_d = frame_cnt + FRAME_W'(1);
          end
        end

        if (enter) begin
          state_d     = FADE;
          frame_cnt_d = '0;
          fade_cnt_d  = '0;
          next_d      = target;
          fading_d    = 1'b1;
          blend_d     = '0;
        end
      end

      FADE: begin
        // Presses and I_auto_en are deliberately ignored here.
        if (tick) begin
          if (fade_cnt == FADE_LAST) begin
            state_d     = HOLD;
            mode_d      = next_q;
            fading_d    = 1'b0;
            blend_d     = '0;
            change_d    = 1'b1;
            frame_cnt_d = '0;
            fade_cnt_d  = '0;
          end else begin
            fade_cnt_d = fade_cnt + 8'd1;
            blend_full = 16'(fade_cnt_d) * 16'(STEP);
            blend_d    = blend_full[7:0];
          end
        end
      end

      default: state_d = HOLD;
    endcase
  end

  assign O_mode        = mode_q;
  assign O_next_mode   = next_q;
  assign O_blend       = blend_q;
  assign O_fading      = fading_q;
  assign O_mode_change = change_q;
  assign O_frame_tick  = frame_tick_q;

endmodule

// File: tb/tb_video_mode_sequencer.sv
// Testbench for video_mode_sequencer with NUM_MODES=5, FRAMES_PER_MODE=4,
// FADE_FRAMES=4, DEBOUNCE_CYCLES=8. Expected output snapshots are queued as
// each frame is driven and compared when the DUT signals the frame tick.
module tb_video_mode_sequencer;

  localparam int MODE_W          = 3;
  localparam int NUM_MODES       = 5;
  localparam int FRAMES_PER_MODE = 4;
  localparam int FADE_FRAMES     = 4;
  localparam int DEBOUNCE_CYCLES = 8;
  localparam int CNT_W           = 20;

  logic              I_pxl_clk = 1'b0;
  logic              I_rst_n;
  logic              I_vs;
  logic              I_vs_pol;
  logic              I_auto_en;
  logic              I_btn_next;
  logic              I_btn_prev;
  logic [MODE_W-1:0] O_mode;
  logic [MODE_W-1:0] O_next_mode;
  logic [7:0]        O_blend;
  logic              O_fading;
  logic              O_mode_change;
  logic              O_frame_tick;

  video_mode_sequencer #(
    .MODE_W         (MODE_W),
    .NUM_MODES      (NUM_MODES),
    .FRAMES_PER_MODE(FRAMES_PER_MODE),
    .FADE_FRAMES    (FADE_FRAMES),
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .CNT_W          (CNT_W)
  ) dut (
    .I_pxl_clk    (I_pxl_clk),
    .I_rst_n      (I_rst_n),
    .I_vs         (I_vs),
    .I_vs_pol     (I_vs_pol),
    .I_auto_en    (I_auto_en),
    .I_btn_next   (I_btn_next),
    .I_btn_prev   (I_btn_prev),
    .O_mode       (O_mode),
    .O_next_mode  (O_next_mode),
    .O_blend      (O_blend),
    .O_fading     (O_fading),
    .O_mode_change(O_mode_change),
    .O_frame_tick (O_frame_tick)
  );

  always #5 I_pxl_clk = ~I_pxl_clk;

  typedef struct {
    int mode;
    int next_mode;
    int blend;
    int fading;
    int change;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_pass   = 0;
  int   n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
    end
  endtask

  function automatic exp_t snap(input int m, input int n, input int b, input int f, input int c);
    exp_t e;
    e.mode      = m;
    e.next_mode = n;
    e.blend     = b;
    e.fading    = f;
    e.change    = c;
    return e;
  endfunction

  task automatic check_outputs(input string tag, input exp_t e);
    check({tag, ".mode"},        32'(O_mode),        32'(e.mode));
    check({tag, ".next_mode"},   32'(O_next_mode),   32'(e.next_mode));
    check({tag, ".blend"},       32'(O_blend),       32'(e.blend));
    check({tag, ".fading"},      32'(O_fading),      32'(e.fading));
    check({tag, ".mode_change"}, 32'(O_mode_change), 32'(e.change));
  endtask

  // One vsync pulse; the tick must appear on the first sample after the
  // sync-deassertion edge, and last exactly one cycle.
  task automatic frame(input exp_t e);
    exp_t got;
    int   waited;
    logic seen;
    @(negedge I_pxl_clk);
    I_vs = I_vs_pol;
    repeat (3) @(negedge I_pxl_clk);
    I_vs = ~I_vs_pol;
    sb.push_back(e);
    waited = 0;
    seen   = 1'b0;
    while (!seen && waited < 6) begin
      @(negedge I_pxl_clk);
      waited++;
      seen = O_frame_tick;
    end
    check("frame.tick_latency", 32'(waited), 32'(1));
    got = sb.pop_front();
    if (seen) begin
      check_outputs("frame", got);
      @(negedge I_pxl_clk);
      check("frame.tick_width", 32'(O_frame_tick), 32'(0));
      check("frame.change_width", 32'(O_mode_change), 32'(0));
    end
  endtask

  // Remaining fade frames after entry, ending in the commit.
  task automatic fade_through(input int m, input int nm);
    for (int k = 1; k < FADE_FRAMES; k++) frame(snap(m, nm, k * (256 / FADE_FRAMES), 1, 0));
    frame(snap(nm, nm, 0, 0, 1));
  endtask

  task automatic auto_cycle(input int m);
    int nm;
    nm = (m + 1) % NUM_MODES;
    for (int k = 0; k < FRAMES_PER_MODE - 1; k++) frame(snap(m, m, 0, 0, 0));
    frame(snap(m, nm, 0, 1, 0));
    fade_through(m, nm);
  endtask

  // Hold the buttons long enough to debounce, release, wait for release to settle.
  task automatic push(input logic nxt, input logic prv, input int hold);
    @(negedge I_pxl_clk);
    I_btn_next = nxt;
    I_btn_prev = prv;
    repeat (hold) @(negedge I_pxl_clk);
    I_btn_next = 1'b0;
    I_btn_prev = 1'b0;
    repeat (14) @(negedge I_pxl_clk);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    I_rst_n    = 1'b1;
    I_vs_pol   = 1'b1;
    I_vs       = 1'b0;
    I_auto_en  = 1'b1;
    I_btn_next = 1'b0;
    I_btn_prev = 1'b0;

    // Reset
    #3 I_rst_n = 1'b0;
    repeat (3) @(negedge I_pxl_clk);
    check_outputs("reset", snap(0, 0, 0, 0, 0));
    check("reset.frame_tick", 32'(O_frame_tick), 32'(0));
    @(negedge I_pxl_clk);
    I_rst_n = 1'b1;
    repeat (2) @(negedge I_pxl_clk);
    check_outputs("post_reset", snap(0, 0, 0, 0, 0));

    // Automatic advance through every mode, including the 4 -> 0 wrap
    for (int m = 0; m < NUM_MODES; m++) auto_cycle(m);

    // Active-low vsync, auto disabled: ticks still detected, no fade
    @(negedge I_pxl_clk);
    I_auto_en = 1'b0;
    I_vs_pol  = 1'b0;
    I_vs      = 1'b1;
    repeat (10) frame(snap(0, 0, 0, 0, 0));

    // Short glitch is rejected
    push(1'b1, 1'b0, 5);
    check_outputs("glitch", snap(0, 0, 0, 0, 0));

    // Next press at mode 0; prev press during the fade is discarded
    push(1'b1, 1'b0, 20);
    check_outputs("press_next", snap(0, 1, 0, 1, 0));
    push(1'b0, 1'b1, 20);
    check_outputs("blocked_prev", snap(0, 1, 0, 1, 0));
    fade_through(0, 1);

    // Prev back to 0, then prev wraps 0 -> 4; next during that fade discarded
    push(1'b0, 1'b1, 20);
    check_outputs("press_prev", snap(1, 0, 0, 1, 0));
    fade_through(1, 0);
    push(1'b0, 1'b1, 20);
    check_outputs("prev_wrap", snap(0, 4, 0, 1, 0));
    push(1'b1, 1'b0, 20);
    check_outputs("blocked_next", snap(0, 4, 0, 1, 0));
    fade_through(0, 4);

    // Both buttons together are ignored
    push(1'b1, 1'b1, 20);
    check_outputs("both_pressed", snap(4, 4, 0, 0, 0));

    // Reset in the middle of a fade
    push(1'b1, 1'b0, 20);
    check_outputs("next_wrap", snap(4, 0, 0, 1, 0));
    frame(snap(4, 0, 64, 1, 0));
    frame(snap(4, 0, 128, 1, 0));
    @(negedge I_pxl_clk);
    #1 I_rst_n = 1'b0;
    #1;
    check_outputs("async_reset", snap(0, 0, 0, 0, 0));
    check("async_reset.frame_tick", 32'(O_frame_tick), 32'(0));
    @(negedge I_pxl_clk);
    I_rst_n   = 1'b1;
    I_auto_en = 1'b1;
    for (int k = 0; k < FRAMES_PER_MODE - 1; k++) frame(snap(0, 0, 0, 0, 0));
    frame(snap(0, 1, 0, 1, 0));

    check("scoreboard_empty", 32'(sb.size()), 32'(0));
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
